// File: rtl/mips_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath,
// with ready-stretched memory access, traps and optional perf counters.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset
//   OpCode     : Instruction[31:26], sampled only in FETCH
//   mem_ready  : data memory done (looked at only in MEM)
//   RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
//   Branch, Jump, ALUOp[1:0] : datapath controls
//   pc_en      : one-cycle pulse per retired instruction
//   state      : FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   illegal    : sticky, unsupported opcode trapped
//   mem_err    : sticky, mem_ready timeout trapped
//   cycle_cnt, instr_cnt : perf counters, live only when the
//                          MC_PERF_CNT_EN macro is defined
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             mem_ready,
    output logic             RegDst,
    output logic             AluSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             Jump,
    output logic [1:0]       ALUOp,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              mem_err_q, mem_err_d;

    logic is_r, is_lw, is_sw, is_br, is_addi, is_j, supported;

    assign is_r      = (op_q == OP_R);
    assign is_lw     = (op_q == OP_LW);
    assign is_sw     = (op_q == OP_SW);
    assign is_br     = (op_q == OP_BEQ) || (op_q == OP_BNE);
    assign is_addi   = (op_q == OP_ADDI);
    assign is_j      = (op_q == OP_J);
    assign supported = is_r | is_lw | is_sw | is_br | is_addi | is_j;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            S_FETCH: begin
                op_d    = OpCode;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (supported) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_br || is_j) begin
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    wait_d  = '0;
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    // TIMEOUT-th consecutive idle MEM cycle
                    wait_d    = '0;
                    state_d   = S_TRAP;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Output logic (Moore, except pc_en on the sw MEM exit)
    always_comb begin
        RegDst   = 1'b0;
        AluSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        ALUOp    = 2'b00;
        pc_en    = 1'b0;
        if (state_q == S_EXEC || state_q == S_MEM ||
            state_q == S_WB) begin
            RegDst   = is_r;
            AluSrc   = is_lw | is_sw | is_addi;
            MemtoReg = is_lw;
            ALUOp    = is_r ? 2'b10 : (is_br ? 2'b01 : 2'b00);
        end
        unique case (state_q)
            S_EXEC: begin
                Branch = is_br;
                Jump   = is_j;
                pc_en  = is_br | is_j;
            end
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                pc_en    = is_sw & mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (pc_en) begin
                instr_q <= instr_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: an instruction-level
// model expands each instruction into its expected per-cycle outputs.
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [5:0]    OpCode;
    logic          mem_ready;
    logic          RegDst, AluSrc, MemtoReg, RegWrite;
    logic          MemRead, MemWrite, Branch, Jump;
    logic [1:0]    ALUOp;
    logic          pc_en;
    logic [2:0]    state;
    logic          illegal, mem_err;
    logic [CW-1:0] cycle_cnt, instr_cnt;

    mips_multicycle_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .OpCode   (OpCode),
        .mem_ready(mem_ready),
        .RegDst   (RegDst),
        .AluSrc   (AluSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .Jump     (Jump),
        .ALUOp    (ALUOp),
        .pc_en    (pc_en),
        .state    (state),
        .illegal  (illegal),
        .mem_err  (mem_err),
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
    );

    typedef struct packed {
        logic       rd, as, m2r, rw, mr, mw, br, j;
        logic [1:0] aop;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [2:0] st;
        ctl_t       c;
        logic       pc;
        logic       ill;
        logic       merr;
    } ent_t;

    ent_t q[$];
    int   pcq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc;
    int   n_pc;
    bit   m_ill, m_merr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic ctl_t stat(input logic [5:0] op);
        ctl_t c = '0;
        if (op == R) begin
            c.rd = 1'b1; c.aop = 2'b10;
        end else if (op == LW) begin
            c.as = 1'b1; c.m2r = 1'b1;
        end else if (op == SW || op == ADDI) begin
            c.as = 1'b1;
        end else if (op == BEQ || op == BNE) begin
            c.aop = 2'b01;
        end
        return c;
    endfunction

    task automatic add(input logic [5:0] op, input logic rdy,
                       input logic [2:0] st, input ctl_t c,
                       input logic pc);
        ent_t e;
        e.op = op; e.rdy = rdy; e.st = st; e.c = c; e.pc = pc;
        e.ill = m_ill; e.merr = m_merr;
        q.push_back(e);
    endtask

    // Expand one instruction into its expected cycles. w = extra
    // MEM cycles before ready; tmo = ready never comes.
    task automatic push_instr(input logic [5:0] op, input int w,
                              input bit tmo);
        ctl_t s, c;
        logic [5:0] jk;
        bit ok;
        jk = ~op;
        s  = stat(op);
        ok = (op == R || op == LW || op == SW || op == BEQ ||
              op == BNE || op == ADDI || op == J);
        add(op, 1'b1, 3'd0, '0, 1'b0);
        add(jk, 1'b1, 3'd1, '0, 1'b0);
        if (!ok) begin
            m_ill = 1'b1;
            repeat (3) add(jk, 1'b1, 3'd7, '0, 1'b0);
            return;
        end
        c = s;
        c.br = (op == BEQ || op == BNE);
        c.j  = (op == J);
        add(jk, 1'b1, 3'd2, c, c.br | c.j);
        if (c.br || c.j) return;
        if (op == LW || op == SW) begin
            c = s;
            c.mr = (op == LW);
            c.mw = (op == SW);
            if (tmo) begin
                repeat (TO) add(jk, 1'b0, 3'd3, c, 1'b0);
                m_merr = 1'b1;
                repeat (3) add(jk, 1'b1, 3'd7, '0, 1'b0);
                return;
            end
            repeat (w) add(jk, 1'b0, 3'd3, c, 1'b0);
            add(jk, 1'b1, 3'd3, c, op == SW);
            if (op == SW) return;
        end
        c = s;
        c.rw = 1'b1;
        add(jk, 1'b1, 3'd4, c, 1'b1);
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b0;
        OpCode    = 6'b0;
        mem_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        cyc    = 1;
        n_pc   = 0;
        m_ill  = 1'b0;
        m_merr = 1'b0;
        q.delete();
        pcq.delete();
    endtask

    task automatic run_n(input int n);
        ent_t e;
        logic [31:0] ec, ei;
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            OpCode    = e.op;
            mem_ready = e.rdy;
            #1;
            chk("state", state, e.st);
            chk("ctl", {RegDst, AluSrc, MemtoReg, RegWrite, MemRead,
                        MemWrite, Branch, Jump, ALUOp}, e.c);
            chk("pc_en", pc_en, e.pc);
            chk("illegal", illegal, e.ill);
            chk("mem_err", mem_err, e.merr);
`ifdef MC_PERF_CNT_EN
            ec = (cyc - 1) % (1 << CW);
            ei = n_pc % (1 << CW);
`else
            ec = 0;
            ei = 0;
`endif
            chk("cycle_cnt", cycle_cnt, ec);
            chk("instr_cnt", instr_cnt, ei);
            if (pc_en === 1'b1) pcq.push_back(cyc);
            if (e.pc) n_pc++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset(2);
        chk("rst_state", state, 0);
        chk("rst_pc_en", pc_en, 0);
        push_instr(R, 0, 0);
        run_all();
        chk("r_pc_cnt", pcq.size(), 1);
        chk("r_pc_at", pcq[0], 4);

        do_reset(1);
        push_instr(LW, 2, 0);
        run_all();
        chk("lw_pc_cnt", pcq.size(), 1);
        chk("lw_pc_at", pcq[0], 7);

        do_reset(1);
        push_instr(SW, 0, 0);
        push_instr(BEQ, 0, 0);
        push_instr(J, 0, 0);
        run_all();
        chk("sbj_pc_cnt", pcq.size(), 3);
        chk("sbj_pc_0", pcq[0], 4);
        chk("sbj_pc_1", pcq[1], 7);
        chk("sbj_pc_2", pcq[2], 10);

        do_reset(1);
        push_instr(ADDI, 0, 0);
        push_instr(BNE, 0, 0);
        push_instr(LW, 0, 0);
        push_instr(SW, 1, 0);
        run_all();
        chk("mix_pc_cnt", pcq.size(), 4);
        chk("mix_pc_last", pcq[3], 17);

        do_reset(1);
        push_instr(BAD, 0, 0);
        run_all();
        chk("ill_flag", illegal, 1);
        chk("ill_state", state, 7);
        chk("ill_pc_cnt", pcq.size(), 0);
        do_reset(1);
        chk("ill_clr", illegal, 0);
        chk("ill_rst_state", state, 0);

        do_reset(1);
        push_instr(SW, 0, 1);
        run_all();
        chk("to_mem_err", mem_err, 1);
        chk("to_memwrite", MemWrite, 0);
        chk("to_state", state, 7);
        chk("to_pc_cnt", pcq.size(), 0);

        do_reset(1);
        push_instr(LW, TO - 1, 0);
        run_all();
        chk("edge_mem_err", mem_err, 0);
        chk("edge_pc_at", pcq[0], 8);

        do_reset(1);
        push_instr(LW, 3, 0);
        run_n(5);
        chk("abort_pc_cnt", pcq.size(), 0);
        do_reset(1);
        push_instr(R, 0, 0);
        run_all();
        chk("abort_restart_pc", pcq[0], 4);

        do_reset(1);
        repeat (3) push_instr(R, 0, 0);
        run_all();
`ifdef MC_PERF_CNT_EN
        chk("perf_instr3", instr_cnt, 3);
        chk("perf_cycle12", cycle_cnt, 12);
`else
        chk("perf_instr3", instr_cnt, 0);
        chk("perf_cycle12", cycle_cnt, 0);
`endif
        repeat (2) push_instr(R, 0, 0);
        run_all();
`ifdef MC_PERF_CNT_EN
        chk("perf_cycle_wrap", cycle_cnt, 4);
        chk("perf_instr5", instr_cnt, 5);
`else
        chk("perf_cycle_wrap", cycle_cnt, 0);
        chk("perf_instr5", instr_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
